// File: rtl/mpsoc_msi_wb_pkg.sv
// Shared Wishbone B3 definitions for the MSI arbiter slice: cycle/burst type
// encodings, a bundled master request type and the select-width helper.
package mpsoc_msi_wb_pkg;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_CONST   = 3'b001;
   localparam logic [2:0] CTI_INC     = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   localparam logic [1:0] BTE_LINEAR  = 2'b00;
   localparam logic [1:0] BTE_WRAP4   = 2'b01;
   localparam logic [1:0] BTE_WRAP8   = 2'b10;
   localparam logic [1:0] BTE_WRAP16  = 2'b11;

   // Default bus widths used by the bundled request type.
   localparam int WB_AW = 32;
   localparam int WB_DW = 32;

   typedef struct packed {
      logic [WB_AW-1:0] adr;
      logic [WB_DW-1:0] dat;
      logic [3:0]       sel;
      logic             we;
      logic             cyc;
      logic             stb;
      logic [2:0]       cti;
      logic [1:0]       bte;
   } wb_req_t;

   // Width of a master index; a single master still gets a 1-bit field.
   function automatic int msel_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mpsoc_msi_arb_rr.sv
// Combinational round-robin pick: scans req starting one past the last
// winner, wrapping modulo N. The caller registers the result.
module mpsoc_msi_arb_rr
   import mpsoc_msi_wb_pkg::*;
#(
   parameter int N = 2,
   localparam int SW = msel_bits(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [SW-1:0] last_i,
   output logic [SW-1:0] winner_o,
   output logic          any_o
);

   // First set request after last_i wins; winner is 0 when nothing requests.
   always_comb begin
      int  idx;
      logic found;
      idx      = 0;
      found    = 1'b0;
      winner_o = '0;
      for (int k = 1; k <= N; k++) begin
         idx = (int'(last_i) + k) % N;
         if (!found && req_i[idx]) begin
            winner_o = SW'(idx);
            found    = 1'b1;
         end
      end
   end

   assign any_o = |req_i;

endmodule

// File: rtl/mpsoc_msi_wb_arbiter.sv
// N-master to 1-slave Wishbone B3 arbiter with round-robin grant held for a
// whole CYC cycle. Optional stall watchdog: define MPSOC_MSI_WB_ARB_TIMEOUT_EN
// to build a counter that answers a stalled strobe with a one-cycle err.
//
// state          | meaning
// IDLE  active=0 | no owner, arbitrate every edge
// OWNED active=1 | grant_q owns the slave until its CYC drops
module mpsoc_msi_wb_arbiter
   import mpsoc_msi_wb_pkg::*;
#(
   parameter int DW          = 32,
   parameter int AW          = 32,
   parameter int NUM_MASTERS = 2,
   parameter int TIMEOUT     = 255,
   localparam int MSEL_BITS  = msel_bits(NUM_MASTERS)
) (
   input  logic                             wb_clk_i,
   input  logic                             wb_rst_i,
   input  logic [NUM_MASTERS-1:0][AW-1:0]   wbm_adr_i,
   input  logic [NUM_MASTERS-1:0][DW-1:0]   wbm_dat_i,
   input  logic [NUM_MASTERS-1:0][3:0]      wbm_sel_i,
   input  logic [NUM_MASTERS-1:0]           wbm_we_i,
   input  logic [NUM_MASTERS-1:0]           wbm_cyc_i,
   input  logic [NUM_MASTERS-1:0]           wbm_stb_i,
   input  logic [NUM_MASTERS-1:0][2:0]      wbm_cti_i,
   input  logic [NUM_MASTERS-1:0][1:0]      wbm_bte_i,
   output logic [NUM_MASTERS-1:0][DW-1:0]   wbm_dat_o,
   output logic [NUM_MASTERS-1:0]           wbm_ack_o,
   output logic [NUM_MASTERS-1:0]           wbm_err_o,
   output logic [NUM_MASTERS-1:0]           wbm_rty_o,
   output logic [AW-1:0]                    wbs_adr_o,
   output logic [DW-1:0]                    wbs_dat_o,
   output logic [3:0]                       wbs_sel_o,
   output logic                             wbs_we_o,
   output logic                             wbs_cyc_o,
   output logic                             wbs_stb_o,
   output logic [2:0]                       wbs_cti_o,
   output logic [1:0]                       wbs_bte_o,
   input  logic [DW-1:0]                    wbs_dat_i,
   input  logic                             wbs_ack_i,
   input  logic                             wbs_err_i,
   input  logic                             wbs_rty_i
);

   if (NUM_MASTERS < 1) begin : g_chk_n
      $error("NUM_MASTERS must be at least 1");
   end
   if (TIMEOUT < 1) begin : g_chk_to
      $error("TIMEOUT must be at least 1");
   end

   logic [MSEL_BITS-1:0] grant_q, grant_d;
   logic [MSEL_BITS-1:0] last_q, last_d;
   logic                 active_q, active_d;
   logic [MSEL_BITS-1:0] rr_winner;
   logic                 rr_any;
   logic                 rearb;
   logic                 to_hit;

   mpsoc_msi_arb_rr #(.N(NUM_MASTERS)) u_rr (
      .req_i    (wbm_cyc_i),
      .last_i   (last_q),
      .winner_o (rr_winner),
      .any_o    (rr_any)
   );

   // Arbitration state; reset parks last_q on the top master so master 0 wins first.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         grant_q  <= '0;
         last_q   <= MSEL_BITS'(NUM_MASTERS - 1);
         active_q <= 1'b0;
      end else begin
         grant_q  <= grant_d;
         last_q   <= last_d;
         active_q <= active_d;
      end
   end

   // Re-arbitrate only when idle or once the owner has released CYC.
   always_comb begin
      rearb    = !active_q || !wbm_cyc_i[grant_q];
      grant_d  = grant_q;
      last_d   = last_q;
      active_d = active_q;
      if (rearb) begin
         active_d = rr_any;
         if (rr_any) begin
            grant_d = rr_winner;
            last_d  = rr_winner;
         end
      end
   end

`ifdef MPSOC_MSI_WB_ARB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);

   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            stall;

   // Count consecutive unanswered strobe cycles; any gap or response restarts it.
   always_comb begin
      stall    = !wb_rst_i && active_q && wbm_cyc_i[grant_q] && wbm_stb_i[grant_q]
                 && !(wbs_ack_i || wbs_err_i || wbs_rty_i);
      to_hit   = stall && (to_cnt_q == TO_W'(TIMEOUT - 1));
      to_cnt_d = (stall && !to_hit) ? to_cnt_q + 1'b1 : '0;
   end

   // Watchdog counter register.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) to_cnt_q <= '0;
      else          to_cnt_q <= to_cnt_d;
   end
`else
   assign to_hit = 1'b0;
`endif

   // Slave side follows the owner; responses go only to the owner. Everything is 0 in reset.
   always_comb begin
      wbs_adr_o = '0;
      wbs_dat_o = '0;
      wbs_sel_o = '0;
      wbs_we_o  = 1'b0;
      wbs_cyc_o = 1'b0;
      wbs_stb_o = 1'b0;
      wbs_cti_o = '0;
      wbs_bte_o = '0;
      wbm_dat_o = '0;
      wbm_ack_o = '0;
      wbm_err_o = '0;
      wbm_rty_o = '0;
      if (!wb_rst_i) begin
         wbs_adr_o = wbm_adr_i[grant_q];
         wbs_dat_o = wbm_dat_i[grant_q];
         wbs_sel_o = wbm_sel_i[grant_q];
         wbs_we_o  = wbm_we_i[grant_q];
         wbs_cti_o = wbm_cti_i[grant_q];
         wbs_bte_o = wbm_bte_i[grant_q];
         wbs_cyc_o = active_q & wbm_cyc_i[grant_q];
         wbs_stb_o = active_q & wbm_cyc_i[grant_q] & wbm_stb_i[grant_q];
         for (int i = 0; i < NUM_MASTERS; i++) begin
            wbm_dat_o[i] = wbs_dat_i;
            if (active_q && (grant_q == MSEL_BITS'(i))) begin
               wbm_ack_o[i] = wbs_ack_i;
               wbm_err_o[i] = wbs_err_i | to_hit;
               wbm_rty_o[i] = wbs_rty_i;
            end
         end
      end
   end

endmodule
